// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with oversampled SCK/SS/MOSI and a one-word tx holding buffer.
// Define SPI_SLAVE_UNDERRUN_EN to add the sticky tx_underrun output.
module spi_slave #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck_in,
  input  logic             ss_in,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic             tx_underrun
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_d, ss_d;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall;

  state_t                 state_q, state_d;
  logic                   load_tx;
  logic                   shifting;
  logic                   reload;
  logic                   accept;

  logic [WIDTH-1:0]       tx_sr, rx_sr, buf_data;
  logic                   buf_full;
  logic [CW-1:0]          cnt;
  logic                   word_done;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ~ss_s & ss_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    case (state_q)
      IDLE:    if (ss_fall) state_d = LOAD;
      LOAD: begin
        load_tx = 1'b1;
        state_d = SHIFT;
      end
      SHIFT:   state_d = SHIFT;
      default: state_d = IDLE;
    endcase
    if (ss_s) begin
      state_d = IDLE;
      load_tx = 1'b0;
    end
  end

  assign shifting = (state_q == SHIFT) && !ss_s;
  // Back-to-back words: the falling edge right after a completed word refills tx_sr.
  assign reload   = load_tx | (shifting & sck_fall & word_done);
  // A word consumed this cycle frees the buffer before tx_load is considered.
  assign accept   = tx_load & (~buf_full | reload);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_data <= tx_data;
      buf_full <= 1'b1;
    end else if (reload) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ss_s) begin
      tx_sr <= '0;
    end else if (reload) begin
      tx_sr <= buf_full ? buf_data : '0;
    end else if (shifting && sck_fall) begin
      tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_s) begin
        rx_sr     <= '0;
        cnt       <= '0;
        word_done <= 1'b0;
      end else if (state_q == LOAD) begin
        cnt       <= '0;
        word_done <= 1'b0;
      end else if (shifting && sck_rise) begin
        rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
        if (cnt == CW'(WIDTH - 1)) begin
          cnt       <= '0;
          rx_data   <= {rx_sr[WIDTH-2:0], mosi_s};
          rx_valid  <= 1'b1;
          word_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (shifting && sck_fall) begin
        word_done <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (reset)                   tx_underrun <= 1'b0;
    else if (reload & ~buf_full) tx_underrun <= 1'b1;
    else if (accept)             tx_underrun <= 1'b0;
  end
`endif

  assign miso     = ~ss_s & tx_sr[WIDTH-1];
  assign tx_ready = ~buf_full;
  assign busy     = ~ss_s;

endmodule
